// File: rtl/cavlc_pkg.sv
// Types and constants shared by the CAVLC coefficient scanner, level-code
// encoder and run encoders.
package cavlc_pkg;

  localparam int COEFF_W = 8;
  localparam int BLK_N   = 16;
  localparam int MAX_T1  = 3;

  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef logic [3:0]                run_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_e;

endpackage

// File: rtl/cavlc_coeff_scanner.sv
// Scans one latched zigzag block from highest to lowest frequency, one
// coefficient per cycle, and builds the CAVLC block statistics.
module cavlc_coeff_scanner #(
  parameter int COEFF_W = 8,
  parameter int BLK_N   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            h264_reset,
  input  logic                            load,
  input  logic [4:0]                      max_coeff,
  input  logic [BLK_N-1:0][COEFF_W-1:0]   coeff_in,
  output logic                            ready,
  output logic                            busy,
  output logic                            done,
  output logic [4:0]                      total_coeff_cnt,
  output logic [1:0]                      trailing_ones_cnt,
  output logic [2:0]                      t1_signs,
  output logic [BLK_N-1:0][COEFF_W-1:0]   level_code_list,
  output logic [4:0]                      level_code_cnt,
  output logic [4:0]                      total_zeros,
  output logic [BLK_N-1:0][3:0]           run_list,
  output logic [4:0]                      run_cnt
);
  import cavlc_pkg::*;

  localparam int IDX_W = $clog2(BLK_N);
  localparam logic [COEFF_W-1:0] MOST_NEG  = {1'b1, {(COEFF_W-1){1'b0}}};
  localparam logic [COEFF_W-1:0] CLAMP_VAL = MOST_NEG + 1'b1;

  scan_state_e                  state_q, state_d;
  logic [BLK_N-1:0][COEFF_W-1:0] blk_q, blk_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         seen_nz_q, seen_nz_d;
  logic                         t1_open_q, t1_open_d;
  run_t                         zero_run_q, zero_run_d;
  logic [4:0]                   tc_q, tc_d;
  logic [1:0]                   t1_q, t1_d;
  logic [2:0]                   t1_signs_q, t1_signs_d;
  logic [BLK_N-1:0][COEFF_W-1:0] lvl_q, lvl_d;
  logic [4:0]                   lvl_cnt_q, lvl_cnt_d;
  logic [4:0]                   tz_q, tz_d;
  run_t [BLK_N-1:0]             run_q, run_d;

  // Classification of the coefficient under the scan pointer.
  logic signed [COEFF_W-1:0] cur;
  logic signed [COEFF_W:0]   cur_ext, cur_mag;
  logic                      cur_nz, cur_t1;

  always_comb begin
    cur     = blk_q[idx_q];
    cur_ext = {cur[COEFF_W-1], cur};
    cur_mag = cur_ext[COEFF_W] ? -cur_ext : cur_ext;
    cur_nz  = (cur != '0);
    cur_t1  = t1_open_q && (cur_mag == (COEFF_W+1)'(1)) && (t1_q < 2'(MAX_T1));
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d    = state_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    seen_nz_d  = seen_nz_q;
    t1_open_d  = t1_open_q;
    zero_run_d = zero_run_q;
    tc_d       = tc_q;
    t1_d       = t1_q;
    t1_signs_d = t1_signs_q;
    lvl_d      = lvl_q;
    lvl_cnt_d  = lvl_cnt_q;
    tz_d       = tz_q;
    run_d      = run_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = load ? SCAN : IDLE;
        if (load) begin
          // -128 has no positive counterpart in the level code; fold it to -127.
          for (int i = 0; i < BLK_N; i++)
            blk_d[i] = (coeff_in[i] == MOST_NEG) ? CLAMP_VAL : coeff_in[i];
          idx_d      = IDX_W'(max_coeff - 5'd1);
          seen_nz_d  = 1'b0;
          t1_open_d  = 1'b1;
          zero_run_d = '0;
          tc_d       = '0;
          t1_d       = '0;
          t1_signs_d = '0;
          lvl_d      = '0;
          lvl_cnt_d  = '0;
          tz_d       = '0;
          run_d      = '0;
        end
      end

      SCAN: begin
        if (cur_nz) begin
          if (cur_t1) begin
            t1_d       = t1_q + 2'd1;
            t1_signs_d = {t1_signs_q[1:0], cur[COEFF_W-1]};
          end else begin
            t1_open_d                  = 1'b0;
            lvl_d[IDX_W'(lvl_cnt_q)]   = cur;
            lvl_cnt_d                  = lvl_cnt_q + 5'd1;
          end
          if (seen_nz_q) run_d[IDX_W'(tc_q - 5'd1)] = zero_run_q;
          zero_run_d = '0;
          tc_d       = tc_q + 5'd1;
          seen_nz_d  = 1'b1;
        end else if (seen_nz_q) begin
          tz_d       = tz_q + 5'd1;
          zero_run_d = zero_run_q + 4'd1;
        end

        if (idx_q == '0) begin
          state_d = DONE;
          // The lowest nonzero's run extends down to index 0.
          if (seen_nz_d) run_d[IDX_W'(tc_d - 5'd1)] = zero_run_d;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || h264_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seen_nz_q  <= 1'b0;
      t1_open_q  <= 1'b1;
      zero_run_q <= '0;
      tc_q       <= '0;
      t1_q       <= '0;
      t1_signs_q <= '0;
      lvl_q      <= '0;
      lvl_cnt_q  <= '0;
      tz_q       <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seen_nz_q  <= seen_nz_d;
      t1_open_q  <= t1_open_d;
      zero_run_q <= zero_run_d;
      tc_q       <= tc_d;
      t1_q       <= t1_d;
      t1_signs_q <= t1_signs_d;
      lvl_q      <= lvl_d;
      lvl_cnt_q  <= lvl_cnt_d;
      tz_q       <= tz_d;
      run_q      <= run_d;
    end
  end

  // NOTE: the latched block is only read during SCAN, which always follows a load, so it needs no reset.
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

  assign ready             = (state_q != SCAN);
  assign busy              = (state_q == SCAN);
  assign done              = (state_q == DONE);
  assign total_coeff_cnt   = tc_q;
  assign trailing_ones_cnt = t1_q;
  assign t1_signs          = t1_signs_q;
  assign level_code_list   = lvl_q;
  assign level_code_cnt    = lvl_cnt_q;
  assign total_zeros       = tz_q;
  assign run_list          = run_q;
  assign run_cnt           = tc_q;

endmodule

// File: tb/tb_cavlc_coeff_scanner.sv
// Scoreboard bench for cavlc_coeff_scanner: a list-based reference model
// predicts each block's statistics and done cycle; a monitor checks on done.
module tb_cavlc_coeff_scanner;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 h264_reset = 1'b0;
  logic                 load = 1'b0;
  logic [4:0]           max_coeff = 5'd16;
  logic [15:0][7:0]     coeff_in = '0;
  logic                 ready, busy, done;
  logic [4:0]           total_coeff_cnt;
  logic [1:0]           trailing_ones_cnt;
  logic [2:0]           t1_signs;
  logic [15:0][7:0]     level_code_list;
  logic [4:0]           level_code_cnt;
  logic [4:0]           total_zeros;
  logic [15:0][3:0]     run_list;
  logic [4:0]           run_cnt;

  cavlc_coeff_scanner #(.COEFF_W(8), .BLK_N(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .h264_reset        (h264_reset),
    .load              (load),
    .max_coeff         (max_coeff),
    .coeff_in          (coeff_in),
    .ready             (ready),
    .busy              (busy),
    .done              (done),
    .total_coeff_cnt   (total_coeff_cnt),
    .trailing_ones_cnt (trailing_ones_cnt),
    .t1_signs          (t1_signs),
    .level_code_list   (level_code_list),
    .level_code_cnt    (level_code_cnt),
    .total_zeros       (total_zeros),
    .run_list          (run_list),
    .run_cnt           (run_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]       tc;
    logic [1:0]       t1;
    logic [2:0]       signs;
    logic [15:0][7:0] lvl;
    logic [4:0]       lvl_cnt;
    logic [4:0]       tz;
    logic [15:0][3:0] run;
    int               done_cycle;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: list the nonzeros in scan order, then derive every statistic
  // from their values and positions.
  function automatic exp_t model(input logic [15:0][7:0] b, input int mc, input int load_cyc);
    exp_t e;
    int   pos[$];
    int   vals[$];
    int   v, n, t1;
    for (int i = mc - 1; i >= 0; i--) begin
      v = int'($signed(b[i]));
      if (v == -128) v = -127;
      if (v != 0) begin
        pos.push_back(i);
        vals.push_back(v);
      end
    end
    n = pos.size();
    t1 = 0;
    while (t1 < n && t1 < 3 && (vals[t1] == 1 || vals[t1] == -1)) t1++;
    e.tc = 5'(n);
    e.t1 = 2'(t1);
    e.signs = '0;
    for (int k = 0; k < t1; k++)
      if (vals[k] < 0) e.signs[t1 - 1 - k] = 1'b1;
    e.lvl = '0;
    for (int k = t1; k < n; k++) e.lvl[k - t1] = 8'(vals[k]);
    e.lvl_cnt = 5'(n - t1);
    e.tz = (n == 0) ? 5'd0 : 5'(pos[0] + 1 - n);
    e.run = '0;
    for (int k = 0; k < n; k++)
      e.run[k] = (k == n - 1) ? 4'(pos[k]) : 4'(pos[k] - pos[k + 1] - 1);
    e.done_cycle = load_cyc + mc + 1;
    return e;
  endfunction

  function automatic logic [7:0] rand_coeff();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 5)       return 8'h00;
    else if (r < 7)  return ($urandom_range(0, 1) != 0) ? 8'h01 : 8'hFF;
    else if (r == 7) return 8'h80;
    else             return 8'($urandom);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding block.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle",  128'(cyc),               128'(e.done_cycle));
          check("total_coeff", 128'(total_coeff_cnt),   128'(e.tc));
          check("trailing1s",  128'(trailing_ones_cnt), 128'(e.t1));
          check("t1_signs",    128'(t1_signs),          128'(e.signs));
          check("level_list",  128'(level_code_list),   128'(e.lvl));
          check("level_cnt",   128'(level_code_cnt),    128'(e.lvl_cnt));
          check("total_zeros", 128'(total_zeros),       128'(e.tz));
          check("run_list",    128'(run_list),          128'(e.run));
          check("run_cnt",     128'(run_cnt),           128'(e.tc));
          check("ready_done",  128'(ready),             128'(1));
        end
      end
    end
  end

  // Drive a load at the current negedge (DUT must be ready) and predict it.
  task automatic issue(input logic [15:0][7:0] b, input logic [4:0] mc);
    coeff_in = b;
    max_coeff = mc;
    load = 1'b1;
    exp_q.push_back(model(b, int'(mc), cyc));
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: got ready=0, expected 1 within 100 cycles");
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"},  128'(ready),             128'(1));
    check({tag, "_busy"},   128'(busy),              128'(0));
    check({tag, "_done"},   128'(done),              128'(0));
    check({tag, "_tc"},     128'(total_coeff_cnt),   128'(0));
    check({tag, "_t1"},     128'(trailing_ones_cnt), 128'(0));
    check({tag, "_signs"},  128'(t1_signs),          128'(0));
    check({tag, "_lvl"},    128'(level_code_list),   128'(0));
    check({tag, "_lvlcnt"}, 128'(level_code_cnt),    128'(0));
    check({tag, "_tz"},     128'(total_zeros),       128'(0));
    check({tag, "_run"},    128'(run_list),          128'(0));
    check({tag, "_runcnt"}, 128'(run_cnt),           128'(0));
  endtask

  logic [15:0][7:0] blk;
  logic [15:0][7:0] blk_b;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    // Mixed block: idx0..8 = {0,3,-1,0,0,-1,1,0,1}
    blk = '0;
    blk[1] = 8'h03; blk[2] = 8'hFF; blk[5] = 8'hFF; blk[6] = 8'h01; blk[8] = 8'h01;
    issue(blk, 5'd16);
    check("busy_in_scan", 128'(busy), 128'(1));
    wait_ready();

    // All-zero block.
    @(negedge clk);
    issue('0, 5'd16);
    wait_ready();

    // Four T1-class values at the top: idx15..12 = {1,1,-1,1}.
    blk = '0;
    blk[15] = 8'h01; blk[14] = 8'h01; blk[13] = 8'hFF; blk[12] = 8'h01;
    @(negedge clk);
    issue(blk, 5'd16);
    wait_ready();

    // AC scan with ignored top entry and -128 clamp.
    blk = '0;
    blk[15] = 8'h05; blk[0] = 8'h80;
    @(negedge clk);
    issue(blk, 5'd15);
    wait_ready();

    // Chroma DC length.
    blk = '0;
    blk[3] = 8'hFE; blk[1] = 8'h01; blk[9] = 8'h07;
    @(negedge clk);
    issue(blk, 5'd4);
    wait_ready();

    // h264_reset mid-scan: aborted block is not predicted, so any done is flagged.
    for (int i = 0; i < 16; i++) blk[i] = 8'h02;
    @(negedge clk);
    coeff_in = blk;
    max_coeff = 5'd16;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_abort", 128'(busy), 128'(1));
    h264_reset = 1'b1;
    @(negedge clk);
    h264_reset = 1'b0;
    check_cleared("abort");
    repeat (20) @(negedge clk);
    blk = '0;
    blk[7] = 8'hFF; blk[4] = 8'h0A; blk[0] = 8'h01;
    issue(blk, 5'd16);
    wait_ready();

    // load during SCAN is ignored.
    blk = '0;
    blk[10] = 8'h04; blk[9] = 8'hFF;
    blk_b = '0;
    blk_b[2] = 8'h33;
    @(negedge clk);
    issue(blk, 5'd16);
    repeat (3) @(negedge clk);
    coeff_in = blk_b;
    max_coeff = 5'd4;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    // Wait for the done cycle, then load the next block in it.
    begin
      int k;
      k = 0;
      while (!done && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("done_seen", 128'(done), 128'(1));
    end
    issue(blk_b, 5'd16);
    wait_ready();

    // Randomized blocks, frequently back-to-back in the DONE cycle.
    for (int n = 0; n < 60; n++) begin
      logic [4:0] mc;
      for (int i = 0; i < 16; i++) blk[i] = rand_coeff();
      case ($urandom_range(0, 3))
        0:       mc = 5'd16;
        1:       mc = 5'd15;
        2:       mc = 5'd4;
        default: mc = 5'($urandom_range(1, 16));
      endcase
      wait_ready();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(blk, mc);
    end

    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: got %0d blocks without done, expected 0", exp_q.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cavlc_coeff_scanner.md
Name: cavlc_coeff_scanner

Overview:
- Upstream stage of the CAVLC level-code encoder.
- Latches one zigzag-ordered residual block and scans it from highest to lowest frequency, one coefficient per cycle.
- Produces the block statistics the encoders consume: total coefficients, trailing ones and their signs, the ordered non-T1 level list, total_zeros and the per-coefficient run_before list.
- Outputs are held stable after the done pulse until the next block is accepted, so the controller can sequence the level, total_zeros and run encoders.

Parameters:
- COEFF_W, 8, signed coefficient width (shared with the level list width).
- BLK_N, 16, maximum coefficients per block.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- h264_reset  in  1  synchronous frame/codec restart, same effect as rst
- load  in  1  accept block; honoured only when ready=1
- max_coeff  in  5  scan length: 16 for 4x4, 15 for AC, 4 for chroma DC; legal values 1..16
- coeff_in  in  COEFF_W x BLK_N  zigzag coefficients, index 0 = lowest frequency
- ready  out  1  high in IDLE or DONE
- busy  out  1  high in SCAN
- done  out  1  one-cycle pulse when results are valid
- total_coeff_cnt  out  5  nonzero count, 0..16
- trailing_ones_cnt  out  2  0..3
- t1_signs  out  3  T1 signs, 1 = negative; first found in bit[trailing_ones_cnt-1], last in bit0; unused bits 0
- level_code_list  out  COEFF_W x BLK_N  non-T1 levels in scan order (high to low frequency)
- level_code_cnt  out  5  valid entries in level_code_list
- total_zeros  out  5  zeros below the highest-frequency nonzero
- run_list  out  4 x BLK_N  run_before per nonzero, in scan order
- run_cnt  out  5  equals total_coeff_cnt

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- On rst or h264_reset:
  - state=IDLE; ready=1; busy=0; done=0.
  - All count outputs, t1_signs and list entries are 0.
  - Reset mid-SCAN aborts the scan with no done pulse.
- FSM:
  - IDLE: load -> SCAN. The block is latched, with any -128 clamped to -127. idx=max_coeff-1 and all accumulators are cleared.
  - SCAN: processes coeff[idx] each cycle and decrements idx. After processing idx=0 -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
  - load in DONE is accepted (-> SCAN) and done still pulses.
- Latency: load at cycle 0 -> done at cycle max_coeff+1. Entries at index >= max_coeff are ignored.
- load while busy=1 is ignored, with no effect on the scan.
- Per-coefficient rules:
  - Flags: seen_nz (a nonzero has been found) and t1_open (starts at 1).
  - Zero coefficient: if seen_nz, total_zeros++ and zero_run++. Zeros do not close t1_open.
  - Nonzero, T1 case (t1_open and |c|==1 and trailing_ones<3): trailing_ones++ and t1_signs <= {t1_signs[1:0], c<0}.
  - Nonzero, otherwise: t1_open=0; level_code_list[level_code_cnt]=c; level_code_cnt++.
  - Every nonzero: if seen_nz, run_list[total_coeff_cnt-1]=zero_run. Then zero_run=0, total_coeff_cnt++, seen_nz=1.
  - At scan end with seen_nz set: run_list[total_coeff_cnt-1]=zero_run, i.e. the lowest nonzero's run counts zeros down to index 0.
- Invariants at done:
  - total_coeff_cnt = trailing_ones_cnt + level_code_cnt.
  - Sum of the first run_cnt entries of run_list = total_zeros.
  - Unused list entries are 0.
- Arithmetic: counters are 5-bit and cannot overflow because the maximum is 16. Magnitude is computed on a COEFF_W+1 path.
- Results remain visible in SCAN only as intermediate values; consumers sample only on done or while ready=1 after a done.

Decomposition:
- cavlc_pkg holds:
  - typedef coeff_t (signed COEFF_W); constants BLK_N=16, MAX_T1=3.
  - enum scan_state_e {IDLE, SCAN, DONE}; typedef run_t (4-bit).
  - This package is shared with the level-code encoder and run encoders.
- Single module; no sub-module. The per-coefficient classify is a small always_comb inside.

Test Plan:
- Mixed block: coeff_in idx0..8 = {0,3,-1,0,0,-1,1,0,1}, rest 0, max_coeff=16 -> done at cycle 17 with:
  - total_coeff_cnt=5, trailing_ones_cnt=3, t1_signs=3'b001.
  - level_code_list={-1,3}, level_code_cnt=2.
  - total_zeros=4, run_list={1,0,2,0,1}.
- All-zero block: total_coeff_cnt=0, trailing_ones_cnt=0, level_code_cnt=0, total_zeros=0, all lists 0, done at cycle 17.
- Four T1-class values: idx15..12 = {1,1,-1,1}, rest 0 -> trailing_ones_cnt=3, t1_signs=3'b001, level_code_list={1}, total_coeff_cnt=4, total_zeros=12, run_list={0,0,0,12}.
- AC and clamp: max_coeff=15, idx15=5 (ignored), idx0=-128 -> total_coeff_cnt=1, level_code_list={-127}, total_zeros=0, done at cycle 16.
- h264_reset at cycle 6 of a scan -> next cycle all outputs 0 and ready=1; no done pulse. A following load produces correct results.
- load pulsed during SCAN with a different block -> ignored, first block results correct. load in the DONE cycle -> second block scanned back-to-back with a second done pulse.
